// File: rtl/lmho_fifo_pkg.sv
// rtl/lmho_fifo_pkg.sv - shared constants and helpers for the lmho line FIFO path
package lmho_fifo_pkg;

    localparam int LMHO_LINE_W = 512;

    function automatic int lmho_lanes_w(input int ratio);
        return $clog2(ratio) + 1;
    endfunction

    // A packer ratio must be a whole power of two of at least two beats.
    function automatic bit lmho_ratio_ok(input int in_w, input int out_w);
        int r;
        if (in_w <= 0 || out_w <= 0 || (out_w % in_w) != 0) return 1'b0;
        r = out_w / in_w;
        return (r >= 2) && ((r & (r - 1)) == 0);
    endfunction

endpackage

// File: rtl/lmho_line_packer.sv
// rtl/lmho_line_packer.sv - packs RATIO narrow beats into one wide line for the line FIFO write port
module lmho_line_packer
    import lmho_fifo_pkg::*;
#(
    parameter int  IN_WIDTH  = 32,
    parameter int  OUT_WIDTH = LMHO_LINE_W,
    localparam int RATIO     = OUT_WIDTH / IN_WIDTH,
    localparam int LW        = lmho_lanes_w(RATIO)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_WIDTH-1:0]  s_data,
    input  logic                 s_last,
    output logic                 m_winc,
    output logic [OUT_WIDTH-1:0] m_wdata,
    input  logic                 m_wfull,
    output logic [LW-1:0]        m_lanes,
    output logic                 m_last
);

    generate
        if (!lmho_ratio_ok(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
            $error("lmho_line_packer: OUT_WIDTH/IN_WIDTH must be a power of two >= 2");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] next_line;
    logic [OUT_WIDTH-1:0] out_q;
    logic [LW-1:0]        cnt;
    logic [LW-1:0]        line_lanes;
    logic [LW-1:0]        hold_lanes;
    logic [LW-1:0]        out_lanes;
    logic                 hold_last;
    logic                 out_last;
    logic                 out_valid;
    logic                 acc_hold;
    logic                 fire;
    logic                 complete;
    logic                 drain;
    logic                 slot_free;

    // acc is always zero above lane cnt, so a single lane write yields a clean line.
    always_comb begin
        fire       = s_valid & ~acc_hold;
        drain      = out_valid & ~m_wfull;
        slot_free  = ~out_valid | drain;
        line_lanes = cnt + LW'(1);
        complete   = fire & (s_last | (cnt == LW'(RATIO - 1)));
        next_line  = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt == LW'(k)) begin
                next_line[k*IN_WIDTH +: IN_WIDTH] = s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc        <= '0;
            cnt        <= '0;
            acc_hold   <= 1'b0;
            hold_lanes <= '0;
            hold_last  <= 1'b0;
            out_q      <= '0;
            out_lanes  <= '0;
            out_last   <= 1'b0;
            out_valid  <= 1'b0;
        end else if (acc_hold) begin
            // Input is stalled; the held line moves over on the first drain.
            if (drain) begin
                out_q     <= acc;
                out_lanes <= hold_lanes;
                out_last  <= hold_last;
                out_valid <= 1'b1;
                acc       <= '0;
                acc_hold  <= 1'b0;
            end
        end else if (complete) begin
            cnt <= '0;
            if (slot_free) begin
                out_q     <= next_line;
                out_lanes <= line_lanes;
                out_last  <= s_last;
                out_valid <= 1'b1;
                acc       <= '0;
            end else begin
                acc        <= next_line;
                hold_lanes <= line_lanes;
                hold_last  <= s_last;
                acc_hold   <= 1'b1;
            end
        end else begin
            if (fire) begin
                acc <= next_line;
                cnt <= line_lanes;
            end
            if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign s_ready = ~acc_hold;
    assign m_winc  = out_valid;
    assign m_wdata = out_q;
    assign m_lanes = out_lanes;
    assign m_last  = out_last;

endmodule

// File: doc/lmho_line_packer.md
# lmho_line_packer

Upstream write-side stage for the 512-bit line FIFOs (`lmho_fifo_std` / `lmho_fifo_fwft`). It accepts a narrow valid/ready beat stream and packs RATIO consecutive beats into one wide line. Packet ends marked by `s_last` flush partial lines. Completed lines are pushed through the FIFO's `winc`/`wdata`/`wfull` write port. A one-line output slot decouples packing from FIFO backpressure, so the stage sustains one beat per cycle while the FIFO has room.

## Interface
- IN_WIDTH, 32: input beat width in bits.
- OUT_WIDTH, 512: line width in bits. Must equal the WIDTH of the downstream FIFO.
- RATIO, OUT_WIDTH/IN_WIDTH (derived localparam): beats per line. Must be an integer power of two, ≥2. Elaboration fails otherwise.
- LW, $clog2(RATIO)+1 (derived localparam): width of the lane count.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat ready; a beat transfers when `s_valid & s_ready` at a rising edge.
- s_data  in  IN_WIDTH  input beat.
- s_last  in  1  final beat of packet; qualified by `s_valid`.
- m_winc  out  1  line push request; connects to FIFO `winc`.
- m_wdata  out  OUT_WIDTH  line data; connects to FIFO `wdata`.
- m_wfull  in  1  connects to FIFO `wfull`.
- m_lanes  out  LW  number of valid beats in `m_wdata`, 1..RATIO.
- m_last  out  1  line closes a packet.

## Operation
State elements:
- Accumulator `acc` (OUT_WIDTH), lane counter `cnt` (LW bits, 0..RATIO-1), last flag.
- Output slot `out_q`, `out_lanes`, `out_last`, `out_valid`.
- `acc_hold` flag: a completed line is waiting in `acc`.

Packing:
- An accepted beat is written to lane `cnt`, bits [cnt*IN_WIDTH +: IN_WIDTH]. Beat 0 occupies the LSBs.
- The line completes when the beat lands in lane RATIO-1, or when `s_last`=1.
- On completion, the line leaves with lanes = `cnt`+1 and last = `s_last`. Unfilled lanes are zero; they must never carry stale data from earlier lines.
- After completion, `cnt` returns to 0 and `acc` clears.

Slot transfer:
- drain = `out_valid & ~m_wfull`.
- A completed line moves into the slot on the same edge if the slot is free or draining that cycle.
- Otherwise the line stays in `acc` and `acc_hold` sets.

Handshake and outputs:
- `s_ready` = `~acc_hold`. It is combinational from state only and has no path from `s_valid`.
- While `acc_hold`=1: on the first drain edge, `acc` moves to the slot and `acc_hold` clears. `s_ready` rises in the following cycle.
- `m_winc` = `out_valid`. The FIFO accepts the line when `m_winc & ~m_wfull`.
- `out_valid` clears on a drain edge, unless it is reloaded on that same edge.
- `m_wdata`, `m_lanes` and `m_last` are stable while `m_winc`=1 and `m_wfull`=1.
- `s_data` and `s_last` are ignored when `s_valid`=0.

## Timing
Reset values (asserted asynchronously):
- `m_winc`=0, `m_wdata`=0, `m_lanes`=0, `m_last`=0, `s_ready`=1.
- Internal: `cnt`=0, `acc`=0, `acc_hold`=0.

Latency and throughput:
- Accept of the completing beat at edge N → `m_winc`=1 in the cycle after N.
- With `m_wfull`=0 throughout, throughput is one beat per cycle and one line per RATIO cycles, with no bubbles.

Boundary cases:
- Completing beat while the slot drains in the same cycle: the line transfers with no bubble.
- Completing beat while the slot is full and `m_wfull`=1: `acc_hold` sets and `s_ready` drops in the next cycle. Input stalls until a drain. The cost is one bubble cycle after the drain edge.
- `s_last` on lane 0: a one-beat line with `m_lanes`=1.
- `s_last` on lane RATIO-1: a full line with `m_last`=1.
- Reset mid-packet or mid-push: the partial `acc` and the slot contents are discarded. `m_winc` drops immediately, with no partial push.

## Structure
- Shared package `lmho_fifo_pkg` holds:
  - `LMHO_LINE_W`=512
  - the function `lmho_lanes_w(ratio)` = $clog2(ratio)+1
  - the power-of-two check used at elaboration.
- Single module with no sub-module. The slot and accumulator are too small to justify splitting.
- Top-level tests instantiate `lmho_fifo_std` downstream with WORDS=4.

## Test plan
- Reset, then 32 beats of 0x0..0x1F with `s_valid`=1 continuously and the FIFO never full → two lines. Line0 lane k = k, line1 lane k = 16+k. `m_lanes`=16 on both. Pushes in cycles 17 and 33. `s_ready` never drops.
- 3-beat packet 0xA,0xB,0xC with `s_last` on the third beat → one line with lanes 0..2 = A,B,C, lanes 3..15 = 0, `m_lanes`=3, `m_last`=1.
- Fill a WORDS=4 FIFO (`wfull`=1), then complete two more lines → first line held in the slot, second in `acc` with `acc_hold`=1 and `s_ready`=0. After one FIFO read, exactly one push occurs. `s_ready` returns one cycle after the drain. No line lost or duplicated.
- Single beat 0x55 with `s_last` → `m_lanes`=1, `m_wdata`=0x55 zero-extended. Send a following 16-beat line → no residue from the 0x55 beat.
- Assert `resetn` low mid-line after 7 beats while the slot holds a line → `m_winc`=0 and `s_ready`=1 immediately. After release, the next 16 beats form a clean line starting at lane 0.
- Random `s_valid` and random FIFO reads over 10k beats with random `s_last` → scoreboard matches all data, lane counts and last flags in order.
